// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate: y = neg ? -a : a (modulo 2^WIDTH).
module div_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional DIV_EARLY_ZERO_EN: divisor=0 bypasses RUN and goes straight to FIX.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH);

   div_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic [WIDTH:0]   prem, diff;

   div_abs #(.WIDTH(WIDTH)) u_abs_dvd (
      .a   (dividend),
      .neg (sign & dividend[WIDTH-1]),
      .y   (dvd_mag)
   );

   div_abs #(.WIDTH(WIDTH)) u_abs_dvs (
      .a   (divisor),
      .neg (sign & divisor[WIDTH-1]),
      .y   (dvs_mag)
   );

   div_abs #(.WIDTH(WIDTH)) u_fix_quo (
      .a   (quo_q),
      .neg (negq_q),
      .y   (quo_fix)
   );

   div_abs #(.WIDTH(WIDTH)) u_fix_rem (
      .a   (rem_q),
      .neg (negr_q),
      .y   (rem_fix)
   );

   // WIDTH+1-bit trial: the top bit of diff is the borrow
   assign prem = {rem_q, quo_q[WIDTH-1]};
   assign diff = prem - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      dvd_d   = dvd_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      zero_d  = zero_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               quo_d   = dvd_mag;
               rem_d   = '0;
               dvs_d   = dvs_mag;
               dvd_d   = dividend;
               negq_d  = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               negr_d  = sign & dividend[WIDTH-1];
               zero_d  = (divisor == '0);
               cnt_d   = '0;
               state_d = RUN;
`ifdef DIV_EARLY_ZERO_EN
               if (divisor == '0) state_d = FIX;
`endif
            end
         end
         RUN: begin
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_d = diff[WIDTH] ? prem[WIDTH-1:0] : diff[WIDTH-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               cnt_d   = '0;
               state_d = FIX;
            end
         end
         FIX: begin
            // first FIX cycle corrects signs, second publishes the result
            if (cnt_q == '0) begin
               quo_d = quo_fix;
               rem_d = rem_fix;
               cnt_d = CW'(1);
            end else begin
               q_d     = zero_q ? '1 : quo_q;
               r_d     = zero_q ? dvd_q : rem_q;
               dz_d    = zero_q;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         dvd_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         zero_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         dvd_q   <= dvd_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         zero_q  <= zero_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign dz   = dz_q;
   assign done = done_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32).
// Zero-divisor latency follows DIV_EARLY_ZERO_EN when defined.
module tb_seq_divider;

   localparam int W = 32;
`ifdef DIV_EARLY_ZERO_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 34;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sign;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         busy;
   logic         done;
   logic         dz;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edz;
   } vec_t;

   vec_t vt[10];

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sign     (sign),
      .dividend (dividend),
      .divisor  (divisor),
      .q        (q),
      .r        (r),
      .busy     (busy),
      .done     (done),
      .dz       (dz)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic go(input logic s, input logic [W-1:0] a,
                     input logic [W-1:0] b);
      sign     = s;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 100);
   endtask

   initial begin
      int n;
      int dcnt;
      vt[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vt[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
      vt[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0,          1'b0};
      vt[3] = '{1'b0, 32'h1234,       32'h0,          32'hFFFFFFFF,   32'h1234,       1'b1};
      vt[4] = '{1'b1, 32'h1234,       32'h0,          32'hFFFFFFFF,   32'h1234,       1'b1};
      vt[5] = '{1'b1, 32'hFFFFFFF0,   32'h0,          32'hFFFFFFFF,   32'hFFFFFFF0,   1'b1};
      vt[6] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
      vt[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
      vt[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000,   1'b0};
      vt[9] = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0};

      rst      = 1'b1;
      start    = 1'b0;
      sign     = 1'b0;
      dividend = '0;
      divisor  = '0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz",   dz,   0);
      check("rst_q",    q,    0);
      check("rst_r",    r,    0);
      #10 rst = 1'b0;

      foreach (vt[i]) begin
         @(negedge clk);
         go(vt[i].s, vt[i].a, vt[i].b);
         check($sformatf("v%0d_busy", i), busy, 1);
         wait_done(n);
         check($sformatf("v%0d_lat", i), n, (vt[i].b == 0) ? ZLAT : 34);
         check($sformatf("v%0d_q", i), q, vt[i].eq);
         check($sformatf("v%0d_r", i), r, vt[i].er);
         check($sformatf("v%0d_dz", i), dz, vt[i].edz);
         check($sformatf("v%0d_busy_done", i), busy, 0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("hold_done", done, 0);
      check("hold_q", q, 32'h0FFFFFFF);
      check("hold_r", r, 32'hF);

      // start mid-RUN is ignored; start in done cycle launches next op
      @(negedge clk);
      go(1'b0, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1;
      sign     = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n);
      check("mid_lat", n + 6, 34);
      check("mid_q", q, 14);
      check("mid_r", r, 2);
      go(1'b0, 32'd1000, 32'd10);
      check("done_pulse", done, 0);
      check("b2b_busy", busy, 1);
      wait_done(n);
      check("b2b_lat", n, 34);
      check("b2b_q", q, 100);
      check("b2b_r", r, 0);

      // async reset at iteration 10
      @(negedge clk);
      go(1'b0, 32'hFFFF, 32'd3);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_q", q, 0);
      check("arst_r", r, 0);
      check("arst_done", done, 0);
      #1 rst = 1'b0;
      dcnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) dcnt++;
      end
      check("arst_no_done", dcnt, 0);
      @(negedge clk);
      go(1'b0, 32'd100, 32'd7);
      wait_done(n);
      check("post_lat", n, 34);
      check("post_q", q, 14);
      check("post_r", r, 2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
